// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Four BCD digits; index 3 is the thousands digit.
  typedef logic [3:0][3:0] bcd4_t;

  localparam int unsigned DEF_SERVE_FRAMES  = 60;
  localparam int unsigned DEF_MISS_FRAMES   = 90;
  localparam int unsigned DEF_LIVES         = 3;
  localparam int unsigned DEF_BASE_SPEED    = 2;
  localparam int unsigned DEF_MAX_SPEED     = 8;
  localparam int unsigned DEF_HITS_PER_STEP = 4;
  localparam int unsigned DEF_PADDLE_SPEED  = 4;

  localparam bcd4_t BCD_MAX = 16'h9999;

  // Ripple-carry BCD increment; wraps 9999 to 0000 (callers saturate).
  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i] == 4'd9) begin
          r[i] = '0;
        end else begin
          r[i]  = v[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Four-digit BCD counter with clear, enable and saturation at 9999.
module bcd_counter
  import pong_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,
  input  logic  en_i,
  output bcd4_t count_o
);

  bcd4_t count_q, count_d;

  // Clear has priority over counting; hold once 9999 is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != BCD_MAX)) begin
      count_d = bcd_inc(count_q);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: serve countdown, live play, miss flash, game over.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES  = DEF_SERVE_FRAMES,
  parameter int unsigned MISS_FRAMES   = DEF_MISS_FRAMES,
  parameter int unsigned LIVES         = DEF_LIVES,
  parameter int unsigned BASE_SPEED    = DEF_BASE_SPEED,
  parameter int unsigned MAX_SPEED     = DEF_MAX_SPEED,
  parameter int unsigned HITS_PER_STEP = DEF_HITS_PER_STEP,
  parameter int unsigned PADDLE_SPEED  = DEF_PADDLE_SPEED
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        nf_in,
  input  logic        start_in,
  input  logic        hit_in,
  input  logic        miss_in,
  output logic        pong_rst_out,
  output logic        controls_en_out,
  output logic [3:0]  puck_speed_out,
  output logic [3:0]  paddle_speed_out,
  output logic [2:0]  state_out,
  output logic [1:0]  lives_out,
  output logic [15:0] score_out,
  output logic        flash_out
);

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LOAD  = 8'(MISS_FRAMES - 1);
  localparam logic [1:0] LIVES_V    = 2'(LIVES);
  localparam logic [3:0] BASE_V     = 4'(BASE_SPEED);
  localparam logic [3:0] MAX_V      = 4'(MAX_SPEED);
  localparam logic [3:0] RALLY_LAST = 4'(HITS_PER_STEP - 1);
  localparam logic [3:0] PADDLE_V   = 4'(PADDLE_SPEED);

  state_t     state_q, state_d;
  logic       start_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rally_q, rally_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] speed_q, speed_d;
  logic       pong_rst_q, pong_rst_d;
  logic       ctrl_en_q, ctrl_en_d;
  logic [3:0] paddle_q, paddle_d;
  logic       flash_q, flash_d;
  logic       start_rise;
  logic       score_clr, score_en;
  bcd4_t      score;

  assign start_rise = start_in & ~start_q;

  // Next-state and datapath control; the gating outputs follow the
  // registered state, so they lag a state change by one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rally_d    = rally_q;
    lives_d    = lives_q;
    speed_d    = speed_q;
    score_clr  = 1'b0;
    score_en   = 1'b0;
    pong_rst_d = (state_q == ST_IDLE) || (state_q == ST_SERVE) || (state_q == ST_OVER);
    ctrl_en_d  = (state_q == ST_PLAY);
    paddle_d   = (state_q == ST_PLAY) ? PADDLE_V : '0;
    flash_d    = (state_q == ST_MISS) & cnt_q[3];

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d   = ST_SERVE;
          lives_d   = LIVES_V;
          speed_d   = BASE_V;
          cnt_d     = SERVE_LOAD;
          rally_d   = '0;
          score_clr = 1'b1;
        end
      end
      ST_SERVE: begin
        if (nf_in) begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else             cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_PLAY: begin
        if (miss_in) begin
          state_d = ST_MISS;
          lives_d = lives_q - 2'd1;
          cnt_d   = MISS_LOAD;
          rally_d = '0;
        end else if (hit_in) begin
          score_en = 1'b1;
          if (rally_q == RALLY_LAST) begin
            rally_d = '0;
            speed_d = (speed_q >= MAX_V) ? MAX_V : speed_q + 4'd1;
          end else begin
            rally_d = rally_q + 4'd1;
          end
        end
      end
      ST_MISS: begin
        if (nf_in) begin
          if (cnt_q == '0) begin
            if (lives_q == '0) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
              cnt_d   = SERVE_LOAD;
              speed_d = BASE_V;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b1;
      cnt_q      <= '0;
      rally_q    <= '0;
      lives_q    <= LIVES_V;
      speed_q    <= BASE_V;
      pong_rst_q <= 1'b1;
      ctrl_en_q  <= 1'b0;
      paddle_q   <= '0;
      flash_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_in;
      cnt_q      <= cnt_d;
      rally_q    <= rally_d;
      lives_q    <= lives_d;
      speed_q    <= speed_d;
      pong_rst_q <= pong_rst_d;
      ctrl_en_q  <= ctrl_en_d;
      paddle_q   <= paddle_d;
      flash_q    <= flash_d;
    end
  end

  bcd_counter u_score (
    .clk_i   (pixel_clk_in),
    .rst_ni  (rst_n_in),
    .clr_i   (score_clr),
    .en_i    (score_en),
    .count_o (score)
  );

  assign pong_rst_out     = pong_rst_q;
  assign controls_en_out  = ctrl_en_q;
  assign puck_speed_out   = speed_q;
  assign paddle_speed_out = paddle_q;
  assign state_out        = state_q;
  assign lives_out        = lives_q;
  assign score_out        = score;
  assign flash_out        = flash_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters.
module tb_pong_match_ctrl;

  logic        clk;
  logic        rst_n;
  logic        nf, start, hit, miss;
  logic        pong_rst, ctrl_en, flash;
  logic [3:0]  puck_speed, paddle_speed;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [15:0] score;

  int unsigned n_vec;
  int unsigned n_err;

  pong_match_ctrl #(
    .SERVE_FRAMES (60),
    .MISS_FRAMES  (90),
    .LIVES        (3),
    .BASE_SPEED   (2),
    .MAX_SPEED    (8),
    .HITS_PER_STEP(4),
    .PADDLE_SPEED (4)
  ) dut (
    .pixel_clk_in    (clk),
    .rst_n_in        (rst_n),
    .nf_in           (nf),
    .start_in        (start),
    .hit_in          (hit),
    .miss_in         (miss),
    .pong_rst_out    (pong_rst),
    .controls_en_out (ctrl_en),
    .puck_speed_out  (puck_speed),
    .paddle_speed_out(paddle_speed),
    .state_out       (state),
    .lives_out       (lives),
    .score_out       (score),
    .flash_out       (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic nf_pulses(input int unsigned n);
    repeat (n) begin
      nf = 1'b1; step(1);
      nf = 1'b0; step(1);
    end
  endtask

  task automatic hits(input int unsigned n);
    repeat (n) begin
      hit = 1'b1; step(1);
      hit = 1'b0; step(1);
    end
  endtask

  task automatic do_miss();
    miss = 1'b1; step(1);
    miss = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; nf = 1'b0; start = 1'b1; hit = 1'b0; miss = 1'b0;
    step(3);
    check("rst_state",  32'(state), 32'd0);
    check("rst_pongrst", 32'(pong_rst), 32'd1);
    check("rst_lives",  32'(lives), 32'd3);
    check("rst_speed",  32'(puck_speed), 32'd2);
    rst_n = 1'b1;
    step(3);
    check("held_start_no_go", 32'(state), 32'd0);

    start = 1'b0; step(1);
    start = 1'b1; step(1);
    check("start_serve", 32'(state), 32'd1);
    check("serve_pongrst", 32'(pong_rst), 32'd1);
    start = 1'b0;

    nf_pulses(59);
    check("serve_59", 32'(state), 32'd1);
    nf = 1'b1; step(1); nf = 1'b0;
    check("serve_60", 32'(state), 32'd2);
    check("play_rst_lag", 32'(pong_rst), 32'd1);
    step(1);
    check("play_pongrst", 32'(pong_rst), 32'd0);
    check("play_ctrl", 32'(ctrl_en), 32'd1);
    check("play_paddle", 32'(paddle_speed), 32'd4);

    hits(4);
    check("spd_4hits", 32'(puck_speed), 32'd3);
    hits(20);
    check("spd_24hits", 32'(puck_speed), 32'd8);
    hits(4);
    check("spd_28hits", 32'(puck_speed), 32'd8);
    check("score_28", 32'(score), 32'h0028);

    do_miss();
    check("miss_state", 32'(state), 32'd3);
    check("miss_lives", 32'(lives), 32'd2);
    step(1);
    check("miss_ctrl", 32'(ctrl_en), 32'd0);
    check("miss_paddle", 32'(paddle_speed), 32'd0);
    check("flash_89", 32'(flash), 32'd1);
    nf_pulses(2);
    check("flash_87", 32'(flash), 32'd0);
    nf_pulses(8);
    check("flash_79", 32'(flash), 32'd1);
    nf_pulses(79);
    check("miss_hold", 32'(state), 32'd3);
    nf_pulses(1);
    check("reserve_state", 32'(state), 32'd1);
    check("reserve_speed", 32'(puck_speed), 32'd2);
    check("reserve_score", 32'(score), 32'h0028);

    nf_pulses(60); do_miss(); nf_pulses(90);
    check("lives_1", 32'(lives), 32'd1);
    nf_pulses(60); do_miss();
    check("lives_0", 32'(lives), 32'd0);
    start = 1'b1;
    nf_pulses(90);
    check("over_state", 32'(state), 32'd4);
    check("over_pongrst", 32'(pong_rst), 32'd1);
    check("over_flash", 32'(flash), 32'd0);
    check("over_score", 32'(score), 32'h0028);
    step(4);
    check("over_held_start", 32'(state), 32'd4);
    start = 1'b0; step(1);
    start = 1'b1; step(1);
    start = 1'b0;
    check("restart_state", 32'(state), 32'd1);
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_score", 32'(score), 32'h0000);

    nf_pulses(60);
    hits(12);
    check("score_12", 32'(score), 32'h0012);
    check("spd_12", 32'(puck_speed), 32'd5);
    hit = 1'b1; miss = 1'b1; step(1);
    hit = 1'b0; miss = 1'b0;
    check("hitmiss_score", 32'(score), 32'h0012);
    check("hitmiss_lives", 32'(lives), 32'd2);
    check("hitmiss_state", 32'(state), 32'd3);

    nf_pulses(90); nf_pulses(60);
    check("sat_play", 32'(state), 32'd2);
    hit = 1'b1; step(9987); hit = 1'b0;
    check("score_9999", 32'(score), 32'h9999);
    hits(1);
    check("score_sat", 32'(score), 32'h9999);
    check("sat_speed", 32'(puck_speed), 32'd8);

    rst_n = 1'b0;
    #2;
    check("arst_state", 32'(state), 32'd0);
    check("arst_pongrst", 32'(pong_rst), 32'd1);
    check("arst_ctrl", 32'(ctrl_en), 32'd0);
    check("arst_speed", 32'(puck_speed), 32'd2);
    check("arst_paddle", 32'(paddle_speed), 32'd0);
    check("arst_lives", 32'(lives), 32'd3);
    check("arst_score", 32'(score), 32'h0000);
    check("arst_flash", 32'(flash), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the pong datapath.
- Runs one match as a sequence of serves: start, serve countdown, live play, miss handling, game over.
- Drives the datapath's reset, puck speed, paddle speed and control gating. Counts lives and a BCD rally score for the HUD overlay.
- Sits between the button/frame-timing logic and the pong datapath, all in the pixel clock domain.

Parameters:
- SERVE_FRAMES, 60, frames the puck is held centred before each serve (1..255).
- MISS_FRAMES, 90, frames of miss flash before the next serve or game over (1..255).
- LIVES, 3, lives per match (1..3).
- BASE_SPEED, 2, puck speed at every serve (1..15).
- MAX_SPEED, 8, puck speed ceiling (BASE_SPEED..15).
- HITS_PER_STEP, 4, paddle hits per +1 puck speed step (1..15).
- PADDLE_SPEED, 4, paddle speed constant.

Ports:
- pixel_clk_in  input  1  single clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- nf_in  input  1  one-cycle new-frame pulse.
- start_in  input  1  synchronized, debounced start button level.
- hit_in  input  1  one-cycle pulse: puck reflected off the paddle.
- miss_in  input  1  datapath game-over level: puck reached x=0.
- pong_rst_out  output  1  active-high reset to the datapath.
- controls_en_out  output  1  gates up/down buttons into the datapath.
- puck_speed_out  output  4  puck speed.
- paddle_speed_out  output  4  paddle speed; 0 when controls are disabled.
- state_out  output  3  current state encoding.
- lives_out  output  2  remaining lives.
- score_out  output  16  four BCD digits; [15:12] is the thousands digit.
- flash_out  output  1  HUD blink enable.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state IDLE, pong_rst_out=1, controls_en_out=0
  - puck_speed_out=BASE_SPEED, paddle_speed_out=0
  - lives_out=LIVES, score_out=0, flash_out=0
  - frame counter=0, rally counter=0
- Asserting rst_n_in mid-match forces reset values immediately, with no clock edge required.
- State encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4. Transitions take effect on the next clock edge; there is no other latency.
- start edge: start_rise = start_in & ~start_q. start_q resets to 1, so a button held through reset does not start a match. start_rise is ignored in SERVE, PLAY and MISS.
- IDLE:
  - pong_rst_out=1.
  - On start_rise go to SERVE. Load lives=LIVES, score=0, speed=BASE_SPEED, frame counter=SERVE_FRAMES-1.
- SERVE:
  - pong_rst_out=1, controls_en_out=0.
  - On each nf_in: if the counter is 0, go to PLAY; otherwise decrement.
  - SERVE therefore spans exactly SERVE_FRAMES nf pulses. pong_rst_out falls on the cycle after the transition.
- PLAY:
  - pong_rst_out=0, controls_en_out=1, paddle_speed_out=PADDLE_SPEED.
  - On hit_in:
    - Score increments in BCD, saturating at 9999.
    - If rally==HITS_PER_STEP-1: rally=0 and puck speed=min(speed+1, MAX_SPEED). Otherwise rally++.
  - On miss_in:
    - lives--, go to MISS, counter=MISS_FRAMES-1, rally=0.
    - controls_en_out=0 and paddle_speed_out=0 from the next cycle.
  - hit_in and miss_in in the same cycle: the miss wins and the hit is dropped (no score change).
- MISS:
  - pong_rst_out=0; the datapath stays frozen by its own latched game-over.
  - flash_out = frame counter bit 3, so it toggles every 8 frames.
  - On nf_in with counter==0: if lives==0 go to OVER; otherwise go to SERVE with counter=SERVE_FRAMES-1 and puck speed=BASE_SPEED.
  - The score is kept across serves.
- OVER:
  - pong_rst_out=1, flash_out=0; score and lives are held for display.
  - On start_rise go to SERVE with fresh lives, score and speed, exactly as from IDLE.
- Counter rules:
  - The frame counter changes only on nf_in in SERVE and MISS.
  - hit_in is ignored outside PLAY; miss_in is ignored outside PLAY.
  - lives never underflows: MISS is entered only from PLAY, and lives is at least 1 in PLAY.

Decomposition:
- Package pong_pkg holds:
  - state_t enum, 3 bits.
  - bcd4_t (four 4-bit digits).
  - Default constants for speeds and frame counts.
- Sub-module bcd_counter: 4-digit BCD counter with enable, clear and saturation at 9999, plus asynchronous active-low reset. It is instantiated once for the score.

Test Plan:
- Reset, then a start_in rising edge → state 1, pong_rst_out=1. After exactly 60 nf pulses → state 2; pong_rst_out=0 and controls_en_out=1 one cycle later.
- 4 hit_in pulses in PLAY → puck_speed 2→3. After 24 hits, speed=8; after 28 hits, still 8 and score_out=16'h0028.
- miss_in in PLAY → state 3, lives 3→2, flash_out toggles every 8 frames. After 90 nf pulses → SERVE with speed=2 and score unchanged.
- Three miss cycles → state 4, lives_out=0, pong_rst_out=1. start_in held high from before gives no restart; release then press → SERVE with lives=3, score=0.
- hit_in and miss_in asserted in the same cycle with score 0x0012 → score stays 0x0012 and lives decrements.
- Score preset to 9999 via 9999 hits, then one more hit → 9999 held. rst_n_in pulled low mid-PLAY without a clock edge → all reset values present.
